// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU front-end sequencer: FSM states and
// command byte field positions.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // Command byte layout; bits [7:6] are reserved and ignored.
    localparam int unsigned CMD_FUNC_LSB = 0;
    localparam int unsigned CMD_FUNC_MSB = 3;
    localparam int unsigned CMD_USE_ACC  = 4;
    localparam int unsigned CMD_CLEAR    = 5;

endpackage

// File: rtl/alu_seq_outreg.sv
// Result holding register with downstream valid/ready handshake.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds zero/negative flags
// captured alongside the result.
module alu_seq_outreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] result,
    input  logic         ready,
`ifdef ALU_SEQ_FLAGS_EN
    output logic         flag_zero,
    output logic         flag_neg,
`endif
    output logic [W-1:0] data,
    output logic         valid
);

    // Capture the result on load; valid drops only after a downstream transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= result;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Flags are held with the data and update only when a new result loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
        end else if (load) begin
            flag_zero <= (result == '0);
            flag_neg  <= result[W-1];
        end
    end
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Byte-stream front end for eight_bit_alu: parses command/operand bytes,
// drives registered ALU inputs, captures the result into an accumulator
// and presents it downstream.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds flag_zero_o / flag_neg_o.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          FUNC_W    = 4,
    parameter logic [DATA_W-1:0]    ACC_RESET = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [FUNC_W-1:0] alu_f_o,
    input  logic [DATA_W-1:0] alu_y_i,
`ifdef ALU_SEQ_FLAGS_EN
    output logic              flag_zero_o,
    output logic              flag_neg_o,
`endif
    output logic              busy_o
);

    state_t            state;
    state_t            state_next;
    logic              in_fire;
    logic              exec;
    logic [DATA_W-1:0] acc;

    assign in_fire = in_valid_i && in_ready_o;
    assign busy_o  = (state != S_CMD);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_CMD;
        else       state <= state_next;
    end

    // Next-state, input ready and execute strobe.
    always_comb begin
        state_next = state;
        in_ready_o = 1'b0;
        exec       = 1'b0;
        case (state)
            S_CMD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (in_data_i[CMD_CLEAR])        state_next = S_CMD;
                    else if (in_data_i[CMD_USE_ACC]) state_next = S_B;
                    else                             state_next = S_A;
                end
            end
            S_A: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_next = S_B;
            end
            S_B: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_next = S_EXEC;
            end
            S_EXEC: begin
                exec       = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                if (out_valid_o && out_ready_i) state_next = S_CMD;
            end
            default: state_next = S_CMD;
        endcase
    end

    // ALU input registers and accumulator; clear overrides use_acc.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= ACC_RESET;
            alu_a_o <= '0;
            alu_b_o <= '0;
            alu_f_o <= '0;
        end else begin
            if (in_fire) begin
                case (state)
                    S_CMD: begin
                        alu_f_o <= in_data_i[CMD_FUNC_MSB:CMD_FUNC_LSB];
                        if (in_data_i[CMD_CLEAR])        acc     <= ACC_RESET;
                        else if (in_data_i[CMD_USE_ACC]) alu_a_o <= acc;
                    end
                    S_A:     alu_a_o <= in_data_i;
                    S_B:     alu_b_o <= in_data_i;
                    default: ;
                endcase
            end
            if (exec) acc <= alu_y_i;
        end
    end

    alu_seq_outreg #(
        .W(DATA_W)
    ) u_outreg (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (exec),
        .result    (alu_y_i),
        .ready     (out_ready_i),
`ifdef ALU_SEQ_FLAGS_EN
        .flag_zero (flag_zero_o),
        .flag_neg  (flag_neg_o),
`endif
        .data      (out_data_o),
        .valid     (out_valid_o)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an adding ALU model (y = a + b).
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_f;
    logic [7:0] alu_y;
    logic       busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic       flag_zero;
    logic       flag_neg;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned xfers  = 0;

    always #5 clk = ~clk;

    assign alu_y = alu_a + alu_b;

    alu_sequencer #(
        .DATA_W   (8),
        .FUNC_W   (4),
        .ACC_RESET(8'h00)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_f_o     (alu_f),
        .alu_y_i     (alu_y),
`ifdef ALU_SEQ_FLAGS_EN
        .flag_zero_o (flag_zero),
        .flag_neg_o  (flag_neg),
`endif
        .busy_o      (busy)
    );

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until accepted; returns 1ns after the transfer edge.
    task automatic send(input logic [7:0] b);
        int unsigned n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned x0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_abf", {alu_a, alu_b, alu_f}, 0);

        // Reset mid-stream after command 0x01
        send(8'h01);
        check("mid_f", alu_f, 1);
        check("mid_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_abf", {alu_a, alu_b, alu_f}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out", {out_valid, out_data}, 0);

        // Basic: 0x12 + 0x34 = 0x46
        x0 = xfers;
        send(8'h01);
        send(8'h12);
        send(8'h34);
        check("basic_exec_ready", in_ready, 0);
        check("basic_exec_valid", out_valid, 0);
        check("basic_abf", {alu_a, alu_b, alu_f}, {8'h12, 8'h34, 4'h1});
        step();
        check("basic_valid", out_valid, 1);
        check("basic_data", out_data, 8'h46);
        check("basic_out_ready_blk", in_ready, 0);
        step();
        check("basic_data_hold", out_data, 8'h46);
        check("basic_valid_drop", out_valid, 0);
        check("basic_idle", busy, 0);
        check("basic_xfers", xfers - x0, 1);

        // Accumulate: 0xF0 + 0x20 = 0x10, then acc + 0x05 = 0x15
        send(8'h01);
        send(8'hF0);
        send(8'h20);
        step();
        check("acc1_data", out_data, 8'h10);
        step();
        send(8'h11);
        check("acc_a", alu_a, 8'h10);
        check("acc_state_b", busy, 1);
        send(8'h05);
        step();
        check("acc2_data", out_data, 8'h15);
        check("acc2_valid", out_valid, 1);
        step();

        // Clear: no output, then acc (0) + 0x07
        x0 = xfers;
        send(8'h21);
        check("clr_idle", busy, 0);
        check("clr_f", alu_f, 1);
        repeat (3) step();
        check("clr_no_valid", out_valid, 0);
        check("clr_no_xfer", xfers - x0, 0);
        send(8'h11);
        check("clr_a", alu_a, 8'h00);
        send(8'h07);
        step();
        check("clr_data", out_data, 8'h07);
        step();

        // Backpressure: 0x0A + 0x0B = 0x15, stray byte held on in_valid
        out_ready = 1'b0;
        x0 = xfers;
        send(8'h01);
        send(8'h0A);
        send(8'h0B);
        in_data  = 8'h99;
        in_valid = 1'b1;
        step();
        for (int unsigned i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8'h15);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        check("bp_ab_untouched", {alu_a, alu_b}, {8'h0A, 8'h0B});
        check("bp_no_xfer", xfers - x0, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_idle", busy, 0);
        check("bp_xfers", xfers - x0, 1);
        check("bp_data_hold", out_data, 8'h15);

`ifdef ALU_SEQ_FLAGS_EN
        send(8'h01);
        send(8'h80);
        send(8'h80);
        step();
        check("flg1_data", out_data, 8'h00);
        check("flg1_flags", {flag_zero, flag_neg}, 2'b10);
        step();
        send(8'h01);
        send(8'h7F);
        send(8'h01);
        step();
        check("flg2_data", out_data, 8'h80);
        check("flg2_flags", {flag_zero, flag_neg}, 2'b01);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
